// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end.
//   btn_state_t              - per-lane press state
//   CLK_HZ                   - board clock frequency
//   DEFAULT_DEBOUNCE_CYCLES  - 10 ms settle window at CLK_HZ
//   DEFAULT_LONG_CYCLES      - 1 s long-press threshold at CLK_HZ
package button_pkg;

    typedef enum logic [1:0] {
        BTN_RELEASED = 2'd0,
        BTN_HELD     = 2'd1,
        BTN_LONG     = 2'd2
    } btn_state_t;

    localparam int CLK_HZ                  = 27_000_000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = CLK_HZ / 100;
    localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/button_lane.sv
// One push-button lane: two-flop synchroniser, debounce counter, press-state
// FSM and long-press hold counter.
//   clk, rst_n     - clock and synchronous active-low reset
//   button_n       - raw asynchronous pin, 0 = pressed
//   pressed        - debounced level, 1 = held
//   press_pulse    - one cycle when a press is accepted
//   release_pulse  - one cycle when a release is accepted
//   long_pulse     - one cycle when a press has been held LONG_CYCLES
module button_lane
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    // Synchroniser carries the raw (active-low) pin level; 1 = released.
    logic              meta_q, meta_d;
    logic              sync_raw_q, sync_raw_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              pressed_q, pressed_d;
    logic              press_pulse_q, press_pulse_d;
    logic              release_pulse_q, release_pulse_d;
    logic              long_pulse_q, long_pulse_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    btn_state_t        state_q, state_d;

    logic sync;
    logic commit;

    always_comb begin
        meta_d     = button_n;
        sync_raw_d = meta_q;
        sync       = ~sync_raw_q;

        // Debounce: the count only advances while the synchronised level
        // disagrees with the committed one; any agreement restarts it.
        deb_cnt_d = deb_cnt_q;
        pressed_d = pressed_q;
        commit    = 1'b0;
        if (sync == pressed_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            commit    = 1'b1;
            pressed_d = sync;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end

        press_pulse_d   = commit & sync;
        release_pulse_d = commit & ~sync;

        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        long_pulse_d = 1'b0;
        case (state_q)
            BTN_RELEASED: begin
                if (press_pulse_d) begin
                    state_d    = BTN_HELD;
                    hold_cnt_d = '0;
                end
            end
            BTN_HELD: begin
                // A release landing on the same cycle as the limit wins.
                if (release_pulse_d) begin
                    state_d = BTN_RELEASED;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = BTN_LONG;
                    long_pulse_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            BTN_LONG: begin
                // hold_cnt stays frozen here, so there is no auto-repeat.
                if (release_pulse_d) begin
                    state_d = BTN_RELEASED;
                end
            end
            default: begin
                state_d = BTN_RELEASED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q          <= 1'b1;
            sync_raw_q      <= 1'b1;
            deb_cnt_q       <= '0;
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            hold_cnt_q      <= '0;
            state_q         <= BTN_RELEASED;
        end else begin
            meta_q          <= meta_d;
            sync_raw_q      <= sync_raw_d;
            deb_cnt_q       <= deb_cnt_d;
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            hold_cnt_q      <= hold_cnt_d;
            state_q         <= state_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: NUM_BUTTONS independent lanes, each turning a raw
// bouncing active-low pin into a clean level plus press/release/long pulses.
//   clk, rst_n     - clock and synchronous active-low reset
//   button_n       - raw pins, 0 = pressed
//   pressed        - debounced levels, 1 = held
//   press_pulse    - one-cycle accepted-press pulses
//   release_pulse  - one-cycle accepted-release pulses
//   long_pulse     - one-cycle long-press pulses
module button_conditioner
    import button_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] button_n,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse,
    output logic [NUM_BUTTONS-1:0] long_pulse
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_lane
            button_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .LONG_CYCLES    (LONG_CYCLES)
            ) u_lane (
                .clk          (clk),
                .rst_n        (rst_n),
                .button_n     (button_n[gi]),
                .pressed      (pressed[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi]),
                .long_pulse   (long_pulse[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int HL  = 2 + DEB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] button_n = '1;
    logic [NB-1:0] pressed, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_n     (button_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw-pin history per lane (index 0 = sampled this edge).
    // A change is accepted when the DEB samples seen through the 2-cycle
    // synchroniser all disagree with the accepted level.
    logic          hist [NB][HL];
    logic [NB-1:0] m_pressed;
    int            m_age [NB];
    bit            m_fired [NB];
    logic [NB-1:0] exp_pressed, exp_press, exp_release, exp_long;

    typedef struct {
        logic          rn;
        logic [NB-1:0] bn;
        logic [NB-1:0] pressed;
        logic [NB-1:0] press;
        logic [NB-1:0] rel;
        logic [NB-1:0] lng;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int l = 0; l < NB; l++) begin
            for (int k = 0; k < HL; k++) hist[l][k] = 1'b1;
            m_pressed[l] = 1'b0;
            m_age[l]     = 0;
            m_fired[l]   = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] bn, input logic rn);
        bit commit;
        exp_press   = '0;
        exp_release = '0;
        exp_long    = '0;
        if (!rn) begin
            model_reset();
        end else begin
            for (int l = 0; l < NB; l++) begin
                for (int k = HL - 1; k > 0; k--) hist[l][k] = hist[l][k-1];
                hist[l][0] = bn[l];
                commit = 1'b1;
                for (int k = 2; k < HL; k++)
                    if ((!hist[l][k]) == m_pressed[l]) commit = 1'b0;
                if (commit) begin
                    if (m_pressed[l]) exp_release[l] = 1'b1;
                    else              exp_press[l]   = 1'b1;
                end
                if (m_pressed[l] && !exp_release[l]) begin
                    m_age[l]++;
                    if (m_age[l] == LNG && !m_fired[l]) begin
                        exp_long[l] = 1'b1;
                        m_fired[l]  = 1'b1;
                    end
                end
                if (commit) begin
                    m_pressed[l] = ~m_pressed[l];
                    m_age[l]     = 0;
                    m_fired[l]   = 1'b0;
                end
            end
        end
        exp_pressed = m_pressed;
    endtask

    // Apply inputs, take one clock edge, then compare all outputs to the model.
    task automatic step(input logic [NB-1:0] bn, input logic rn);
        button_n = bn;
        rst_n    = rn;
        @(posedge clk);
        model_edge(bn, rn);
        #1;
        check("pressed",       pressed,       exp_pressed);
        check("press_pulse",   press_pulse,   exp_press);
        check("release_pulse", release_pulse, exp_release);
        check("long_pulse",    long_pulse,    exp_long);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b11, 1'b1);
    endtask

    initial begin
        int press_at, long_at, rel_at, n_long, n_press1, bad;
        logic [NB-1:0] lvl, bn;

        model_reset();

        // Reset with both buttons held, then held through reset, then release.
        for (int i = 0; i < 3; i++)  vecs[i] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 3; i < 8; i++)  vecs[i] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[8] = '{1'b1, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00};
        vecs[9] = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int i = 10; i < 15; i++) vecs[i] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
        vecs[15] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].bn, vecs[i].rn);
            check($sformatf("vec%0d_pressed", i), pressed,       vecs[i].pressed);
            check($sformatf("vec%0d_press",   i), press_pulse,   vecs[i].press);
            check($sformatf("vec%0d_release", i), release_pulse, vecs[i].rel);
            check($sformatf("vec%0d_long",    i), long_pulse,    vecs[i].lng);
        end
        idle(8);

        // Clean press on lane 0; lane 1 must stay quiet.
        press_at = -1; bad = 0;
        for (int i = 1; i <= 10; i++) begin
            step(2'b10, 1'b1);
            if (press_pulse[0] && press_at < 0) press_at = i;
            if (pressed[1] || press_pulse[1]) bad++;
        end
        check("clean_press_latency", 2'(press_at), 2'(6));
        checks++;
        if (press_at != 6 || bad != 0) begin
            errors++;
            $display("FAIL clean_press: press at %0d expected 6, lane1 activity %0d expected 0", press_at, bad);
        end
        idle(10);

        // Bounce 0,1,0,1 then hold 0: pulse 6 cycles after the last fall.
        press_at = -1;
        for (int i = 1; i <= 14; i++) begin
            step((i <= 4) ? {1'b1, logic'(i % 2 == 0)} : 2'b10, 1'b1);
            if (press_pulse[0] && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at != 10) begin
            errors++;
            $display("FAIL bounce_press: press at step %0d expected 10", press_at);
        end
        idle(10);

        // Glitch on lane 1: three cycles low is too short to accept.
        bad = 0;
        for (int i = 1; i <= 12; i++) begin
            step((i <= 3) ? 2'b01 : 2'b11, 1'b1);
            if (pressed[1] || press_pulse[1] || release_pulse[1]) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_reject: lane1 activity %0d expected 0", bad);
        end

        // Long press: hold 40 cycles, then release.
        press_at = -1; long_at = -1; rel_at = -1; n_long = 0;
        for (int i = 1; i <= 50; i++) begin
            step((i <= 40) ? 2'b10 : 2'b11, 1'b1);
            if (press_pulse[0] && press_at < 0) press_at = i;
            if (long_pulse[0]) begin n_long++; if (long_at < 0) long_at = i; end
            if (release_pulse[0] && rel_at < 0) rel_at = i;
        end
        checks++;
        if (press_at != 6 || long_at != 26 || n_long != 1 || rel_at != 46) begin
            errors++;
            $display("FAIL long_press: press %0d/6 long %0d/26 count %0d/1 release %0d/46",
                     press_at, long_at, n_long, rel_at);
        end
        idle(6);

        // Release accepted on the very cycle the long limit is reached.
        n_long = 0; rel_at = -1;
        for (int i = 1; i <= 32; i++) begin
            step((i <= 20) ? 2'b01 : 2'b11, 1'b1);
            if (long_pulse[1]) n_long++;
            if (release_pulse[1] && rel_at < 0) rel_at = i;
        end
        checks++;
        if (n_long != 0 || rel_at != 26) begin
            errors++;
            $display("FAIL release_at_limit: long count %0d expected 0, release at %0d expected 26", n_long, rel_at);
        end
        idle(4);

        // Reset mid-hold: no release pulse, press re-fires after reset.
        for (int i = 1; i <= 16; i++) step(2'b10, 1'b1);
        step(2'b10, 1'b0);
        check("midhold_reset_pressed", pressed,       2'b00);
        check("midhold_reset_release", release_pulse, 2'b00);
        press_at = -1;
        for (int i = 1; i <= 10; i++) begin
            step(2'b10, 1'b1);
            if (press_pulse[0] && press_at < 0) press_at = i;
        end
        checks++;
        if (press_at != 6) begin
            errors++;
            $display("FAIL midhold_repress: press at %0d expected 6", press_at);
        end
        idle(10);

        // Randomised traffic against the model.
        lvl = '1;
        n_press1 = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int l = 0; l < NB; l++)
                if ($urandom_range(39) == 0) lvl[l] = ~lvl[l];
            bn = lvl;
            for (int l = 0; l < NB; l++)
                if ($urandom_range(7) == 0) bn[l] = ~bn[l];
            step(bn, ($urandom_range(599) == 0) ? 1'b0 : 1'b1);
            if (press_pulse[1]) n_press1++;
        end
        checks++;
        if (n_press1 == 0) begin
            errors++;
            $display("FAIL random_activity: lane1 presses %0d expected nonzero", n_press1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
